// File: rtl/rs_issue_scheduler.sv
// Reservation-station controller: lowest-free allocation on the dispatch side and
// round-robin issue with a registered valid/ready handshake to one functional unit.
module rs_issue_scheduler #(
  parameter int NUM_RS    = 4,
  parameter int IDX_WIDTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [NUM_RS-1:0]    rs_busy,
  input  logic [NUM_RS-1:0]    rs_ready,
  input  logic                 dispatch_valid,
  output logic                 dispatch_stall,
  output logic [NUM_RS-1:0]    rs_enable,
  output logic                 issue_valid,
  output logic [NUM_RS-1:0]    issue_grant,
  output logic [IDX_WIDTH-1:0] issue_index,
  input  logic                 fu_ready,
  output logic                 issue_accept,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [IDX_WIDTH:0]   occupancy
);

  localparam int OCC_W = IDX_WIDTH + 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [NUM_RS-1:0]      grant_q, grant_d;
  logic [NUM_RS-1:0]      last_accept_q, last_accept_d;
  logic [IDX_WIDTH-1:0]   index_q, index_d;
  logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   stall_count_q;

  logic [NUM_RS-1:0]      free;
  logic [NUM_RS-1:0]      cand;
  logic [IDX_WIDTH-1:0]   arb_ptr;
  logic [IDX_WIDTH-1:0]   arb_idx;
  logic [IDX_WIDTH-1:0]   scan_idx;
  logic                   arb_found;

  // Allocation: lowest free station, suppressed during reset and flush.
  always_comb begin
    free           = ~rs_busy;
    rs_enable      = '0;
    dispatch_stall = 1'b0;
    if (reset && !flush && dispatch_valid) begin
      if (free != '0) rs_enable = free & (~free + NUM_RS'(1));
      else            dispatch_stall = 1'b1;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      occupancy = occupancy + OCC_W'(rs_busy[i]);
    end
  end

  assign issue_valid  = (state_q == HOLD);
  assign issue_grant  = grant_q;
  assign issue_index  = index_q;
  assign issue_accept = reset & issue_valid & fu_ready;
  assign stall_count  = stall_count_q;

  // On an accept the search restarts just past the accepted station and also
  // excludes it, so back-to-back issue never re-grants a stale ready flag.
  always_comb begin
    arb_ptr   = issue_accept ? index_q + IDX_WIDTH'(1) : rr_ptr_q;
    cand      = rs_ready & ~(last_accept_q | (issue_accept ? grant_q : '0));
    arb_found = 1'b0;
    arb_idx   = '0;
    scan_idx  = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      scan_idx = arb_ptr + IDX_WIDTH'(i);
      if (!arb_found && cand[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    index_d       = index_q;
    rr_ptr_d      = rr_ptr_q;
    last_accept_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = HOLD;
          grant_d = NUM_RS'(1) << arb_idx;
          index_d = arb_idx;
        end
      end
      HOLD: begin
        if (fu_ready) begin
          last_accept_d = grant_q;
          rr_ptr_d      = index_q + IDX_WIDTH'(1);
          if (arb_found) begin
            grant_d = NUM_RS'(1) << arb_idx;
            index_d = arb_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            index_d = '0;
          end
        end else if ((rs_ready & grant_q) == '0) begin
          state_d = IDLE;
          grant_d = '0;
          index_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      index_q       <= '0;
      rr_ptr_q      <= '0;
      last_accept_q <= '0;
    end else if (flush) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      index_q       <= '0;
      last_accept_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      index_q       <= index_d;
      rr_ptr_q      <= rr_ptr_d;
      last_accept_q <= last_accept_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      stall_count_q <= '0;
    else if (dispatch_stall && stall_count_q != '1)
      stall_count_q <= stall_count_q + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler: expected issue state is queued as each
// cycle's stimulus is applied and compared after the following clock edge.
module tb_rs_issue_scheduler;

  localparam int NRS = 4;
  localparam int IW  = 2;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset, flush, dispatch_valid, fu_ready;
  logic [NRS-1:0] rs_busy, rs_ready;
  logic          dispatch_stall, issue_valid, issue_accept;
  logic [NRS-1:0] rs_enable, issue_grant;
  logic [IW-1:0] issue_index;
  logic [CW-1:0] stall_count;
  logic [IW:0]   occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic          iv;
    logic [NRS-1:0] grant;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sbq[$];

  rs_issue_scheduler #(.NUM_RS(NRS), .IDX_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .rs_busy(rs_busy), .rs_ready(rs_ready),
    .dispatch_valid(dispatch_valid), .dispatch_stall(dispatch_stall), .rs_enable(rs_enable),
    .issue_valid(issue_valid), .issue_grant(issue_grant), .issue_index(issue_index),
    .fu_ready(fu_ready), .issue_accept(issue_accept), .stall_count(stall_count),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the issue state expected after the next edge, clock, then compare.
  task automatic step(input string tag, input logic iv, input logic [NRS-1:0] g, input logic [IW-1:0] idx);
    exp_t e;
    sbq.push_back('{iv: iv, grant: g, idx: idx});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({tag, "_valid"}, 32'(issue_valid), 32'(e.iv));
    chk({tag, "_grant"}, 32'(issue_grant), 32'(e.grant));
    chk({tag, "_index"}, 32'(issue_index), 32'(e.idx));
  endtask

  task automatic settle_chk(input string tag, input logic acc);
    #1;
    chk({tag, "_accept"}, 32'(issue_accept), 32'(acc));
  endtask

  logic [NRS-1:0] busy_tab [3] = '{4'b0000, 4'b0111, 4'b1010};
  logic [NRS-1:0] en_tab   [3] = '{4'b0001, 4'b1000, 4'b0001};
  logic [IW:0]    occ_tab  [3] = '{3'd0, 3'd3, 3'd2};

  initial begin
    reset = 1'b0; flush = 1'b0; rs_busy = 4'b1111; rs_ready = 4'b1111;
    dispatch_valid = 1'b1; fu_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_grant", 32'(issue_grant), 32'd0);
    chk("rst_index", 32'(issue_index), 32'd0);
    chk("rst_stall_count", 32'(stall_count), 32'd0);
    chk("rst_rs_enable", 32'(rs_enable), 32'd0);
    chk("rst_dispatch_stall", 32'(dispatch_stall), 32'd0);
    chk("rst_accept", 32'(issue_accept), 32'd0);

    reset = 1'b1; dispatch_valid = 1'b0; rs_busy = '0; fu_ready = 1'b0;
    settle_chk("release", 1'b0);
    step("release", 1'b1, 4'b0001, 2'd0);

    // Round robin with constant ready and an always-ready unit.
    fu_ready = 1'b1;
    settle_chk("rr0", 1'b1); step("rr1", 1'b1, 4'b0010, 2'd1);
    settle_chk("rr1", 1'b1); step("rr2", 1'b1, 4'b0100, 2'd2);
    settle_chk("rr2", 1'b1); step("rr3", 1'b1, 4'b1000, 2'd3);
    settle_chk("rr3", 1'b1); step("rr4", 1'b1, 4'b0001, 2'd0);

    // Backpressure on station 1.
    rs_ready = 4'b0110;
    settle_chk("bp_acc0", 1'b1); step("bp_g1", 1'b1, 4'b0010, 2'd1);
    fu_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle_chk("bp_hold", 1'b0); step("bp_hold", 1'b1, 4'b0010, 2'd1);
    end
    fu_ready = 1'b1;
    settle_chk("bp_acc1", 1'b1); step("bp_g2", 1'b1, 4'b0100, 2'd2);

    rs_ready = 4'b1000;
    settle_chk("to3", 1'b1); step("to3", 1'b1, 4'b1000, 2'd3);
    fu_ready = 1'b0;

    // Allocation patterns, issue held on station 3 meanwhile.
    rs_busy = 4'b1011; dispatch_valid = 1'b1; #1;
    chk("alloc_enable", 32'(rs_enable), 32'b0100);
    chk("alloc_stall", 32'(dispatch_stall), 32'd0);
    chk("alloc_occ", 32'(occupancy), 32'd3);
    step("alloc", 1'b1, 4'b1000, 2'd3);
    rs_busy = 4'b1111; #1;
    chk("full_enable", 32'(rs_enable), 32'd0);
    chk("full_stall", 32'(dispatch_stall), 32'd1);
    chk("full_occ", 32'(occupancy), 32'd4);
    for (int i = 0; i < 5; i++) step("stall5", 1'b1, 4'b1000, 2'd3);
    chk("stall_count5", 32'(stall_count), 32'd5);

    // Flush while holding station 3; accept still visible combinationally.
    flush = 1'b1; fu_ready = 1'b1; #1;
    chk("flush_accept", 32'(issue_accept), 32'd1);
    chk("flush_stall", 32'(dispatch_stall), 32'd0);
    chk("flush_enable", 32'(rs_enable), 32'd0);
    step("flush", 1'b0, 4'b0000, 2'd0);
    chk("flush_stall_count", 32'(stall_count), 32'd5);
    flush = 1'b0; fu_ready = 1'b0; rs_ready = 4'b1001;
    step("post_flush", 1'b1, 4'b1000, 2'd3);

    // Saturation of the stall counter (6 edges counted so far? no: 5 before, 1 after flush).
    for (int i = 0; i < 9; i++) step("sat", 1'b1, 4'b1000, 2'd3);
    chk("stall_count_max", 32'(stall_count), 32'd15);
    for (int i = 0; i < 3; i++) step("sat_hold", 1'b1, 4'b1000, 2'd3);
    chk("stall_count_sat", 32'(stall_count), 32'd15);

    for (int i = 0; i < 3; i++) begin
      rs_busy = busy_tab[i]; #1;
      chk("alloc_tab_enable", 32'(rs_enable), 32'(en_tab[i]));
      chk("alloc_tab_occ", 32'(occupancy), 32'(occ_tab[i]));
    end
    dispatch_valid = 1'b0; rs_busy = 4'b1111; #1;
    chk("idle_stall", 32'(dispatch_stall), 32'd0);
    chk("idle_enable", 32'(rs_enable), 32'd0);

    // Withdrawal of the granted station before the unit accepts.
    rs_ready = 4'b0100; fu_ready = 1'b1;
    settle_chk("wd_pre", 1'b1); step("wd_g2", 1'b1, 4'b0100, 2'd2);
    rs_ready = 4'b0000; fu_ready = 1'b0;
    settle_chk("wd_drop", 1'b0); step("wd_drop", 1'b0, 4'b0000, 2'd0);
    settle_chk("wd_idle", 1'b0); step("wd_idle", 1'b0, 4'b0000, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Controller for a bank of NUM_RS reservation stations that feed one shared functional unit.
- Dispatch side: picks a free station for each dispatched instruction and drives that station's one-hot load enable.
- Issue side: round-robin arbitration among ready stations, with a registered valid/ready handshake to the functional unit.
- Also counts dispatch-stall cycles for performance monitoring.
- Sits between the decode/rename stage and the reservation-station bank.

Parameters:
NUM_RS, 4, number of reservation stations managed (power of two, >=2)
IDX_WIDTH, 2, log2(NUM_RS)
CNT_WIDTH, 16, width of stall-cycle counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
flush  input  1  mispredict flush; synchronous, active-high
rs_busy  input  NUM_RS  busy flag of each station
rs_ready  input  NUM_RS  ready flag of each station (operands resolved)
dispatch_valid  input  1  decode has an instruction to place this cycle
dispatch_stall  output  1  no free station; decode must hold
rs_enable  output  NUM_RS  one-hot load enable to the chosen station (combinational)
issue_valid  output  1  registered: issue_grant/issue_index are valid
issue_grant  output  NUM_RS  registered one-hot of the station being issued
issue_index  output  IDX_WIDTH  binary encoding of issue_grant
fu_ready  input  1  functional unit accepts on this cycle when issue_valid=1
issue_accept  output  1  issue_valid & fu_ready; station may clear
stall_count  output  CNT_WIDTH  saturating count of cycles with dispatch_stall=1
occupancy  output  IDX_WIDTH+1  popcount of rs_busy (combinational)

Behaviour:
- Reset (reset=0 at edge): issue_valid=0, issue_grant=0, issue_index=0, rr_ptr=0, stall_count=0, last_accept mask=0. Reset has priority over flush and all other activity.
- Combinational outputs during reset: rs_enable=0, dispatch_stall=0, issue_accept=0.
- Allocation (combinational):
  - free = ~rs_busy.
  - If dispatch_valid and free!=0: rs_enable = one-hot of the lowest-index free bit; dispatch_stall=0.
  - If dispatch_valid and free==0: rs_enable=0, dispatch_stall=1.
  - dispatch_valid=0: rs_enable=0, dispatch_stall=0.
  - flush=1 forces rs_enable=0 and dispatch_stall=0.
- Issue FSM, states IDLE (issue_valid=0) and HOLD (issue_valid=1).
  - Candidate set cand = rs_ready & ~last_accept. last_accept is the one-hot of the station accepted in the previous cycle; it masks a station whose ready flag has not yet dropped.
  - IDLE: if cand!=0, register grant = first set bit of cand searching upward from rr_ptr with wrap-around. Go to HOLD. Latency from ready to issue_valid = 1 cycle.
  - HOLD, fu_ready=0: grant held stable; no re-arbitration.
  - HOLD, fu_ready=1: issue_accept=1. At the edge: rr_ptr = issue_index+1 (mod NUM_RS); last_accept = issue_grant. Re-arbitrate the same edge, excluding the accepted station. If no candidate, go to IDLE. Back-to-back issue every cycle is supported.
  - HOLD, granted station's rs_ready=0 and fu_ready=0 (withdrawn): drop to IDLE next edge; no accept.
  - last_accept clears to 0 on any edge without accept.
- flush=1 at an edge:
  - issue_valid->0, issue_grant->0, last_accept->0, state IDLE.
  - rr_ptr unchanged; stall_count unchanged.
  - issue_accept is still asserted combinationally if fu_ready is high that cycle. The FU must ignore it under flush.
- stall_count: increments by 1 on each edge with dispatch_stall=1; saturates at all-ones. Not cleared by flush.
- Ready and busy are both sampled only at edges. Simultaneous allocation and issue of different stations is legal and independent.

Test Plan:
- Reset: hold reset=0 two cycles with rs_ready=4'b1111 -> issue_valid=0, stall_count=0. After release, issue_valid=1 next cycle with issue_index=0.
- Round-robin: rs_ready=4'b1111, fu_ready=1 constant -> issue_index sequence 0,1,2,3,0 on consecutive cycles, issue_accept=1 every cycle.
- Backpressure: rs_ready=4'b0110, fu_ready=0 for 3 cycles then 1 -> issue_index=1 held 4 cycles, one accept. Then issue_index=2 the next cycle.
- Allocation/stall: rs_busy=4'b1011, dispatch_valid=1 -> rs_enable=4'b0100. With rs_busy=4'b1111 held 5 cycles -> dispatch_stall=1 and stall_count=5. Preload stall_count at all-ones -> it stays all-ones.
- Flush mid-hold: HOLD with issue_index=3, fu_ready=0, flush=1 -> next cycle issue_valid=0, grant=0. With rs_ready=4'b1000 after flush, issue_index=3 is re-granted (rr_ptr unchanged).
- Withdrawal: grant on station 2, then rs_ready[2] drops with fu_ready=0 -> issue_valid=0 next cycle, issue_accept never asserted.
